spm_boot_sequencer: RTL and testbench

Power-up and reload sequencer for the single-port program memory of the RISC SPM machine.
- Holds the processor in reset while it streams a program image over a valid/ready byte interface into memory, one word per cycle.
- Optionally zero-fills the unused memory, then releases the processor reset.
- Owns the memory port mux: the loader drives memory while loading; the processor drives it while running.

---
 rtl/spm_boot_sequencer_if.sv | 41 ++++
 rtl/spm_boot_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_spm_boot_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spm_boot_sequencer_if.sv
// -----------------------------------------------------------------------------
// spm_boot_sequencer_if
//
// Byte-stream load channel feeding the program-memory boot sequencer.
// A beat transfers on a rising clock edge when ld_valid and ld_ready are both
// high; ld_last marks the final byte of the program image.
//
// Signals:
//   ld_valid  source -> sequencer  load byte valid
//   ld_data   source -> sequencer  load byte (word_size bits)
//   ld_last   source -> sequencer  final byte of image, qualified by ld_valid
//   ld_ready  sequencer -> source  sequencer accepts a byte this cycle
//
// Modports:
//   master  image source (drives valid/data/last, observes ready)
//   slave   boot sequencer (observes valid/data/last, drives ready)
// -----------------------------------------------------------------------------
interface spm_boot_sequencer_if #(
    parameter int word_size = 8
) ();

    logic                 ld_valid;
    logic [word_size-1:0] ld_data;
    logic                 ld_last;
    logic                 ld_ready;

    modport master (
        output ld_valid,
        output ld_data,
        output ld_last,
        input  ld_ready
    );

    modport slave (
        input  ld_valid,
        input  ld_data,
        input  ld_last,
        output ld_ready
    );

endinterface : spm_boot_sequencer_if

// File: rtl/spm_boot_sequencer.sv
// -----------------------------------------------------------------------------
// spm_boot_sequencer
//
// Power-up and reload sequencer for the single-port program memory of the
// RISC SPM machine. While the processor is held in reset it streams a program
// image into memory one word per cycle, optionally zero-fills the rest of the
// memory, holds the processor reset for a few more cycles and then releases
// it. It also owns the memory port mux: the loader drives the memory while
// loading/clearing, the processor drives it while running.
//
// Parameters:
//   word_size   memory data word / load byte width
//   addr_size   memory address width, depth D = 2**addr_size
//   clear_en    1 = zero-fill from the word after the image up to D-1
//   rel_cycles  cycles cpu_rst stays low in RELEASE (>= 1)
//
// Ports:
//   clk           system clock, all state on the rising edge
//   rst           synchronous active-low reset
//   start         pulse: begin a load (honoured in IDLE and RUN only)
//   ld            load byte stream (slave side of spm_boot_sequencer_if)
//   cpu_address   processor memory address
//   cpu_data      processor write data
//   cpu_write     processor write strobe
//   mem_address   to Memory_Unit address
//   mem_data_in   to Memory_Unit data_in
//   mem_write     to Memory_Unit write
//   cpu_rst       active-low processor/controller reset, registered
//   busy          high in LOAD, CLEAR and RELEASE
//   done          high in RUN
//   err_overflow  sticky: image was longer than D words
//   load_count    words accepted in the current load (0..D)
// -----------------------------------------------------------------------------
module spm_boot_sequencer #(
    parameter int word_size  = 8,
    parameter int addr_size  = 8,
    parameter int clear_en   = 1,
    parameter int rel_cycles = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    spm_boot_sequencer_if.slave  ld,
    input  logic [addr_size-1:0] cpu_address,
    input  logic [word_size-1:0] cpu_data,
    input  logic                 cpu_write,
    output logic [addr_size-1:0] mem_address,
    output logic [word_size-1:0] mem_data_in,
    output logic                 mem_write,
    output logic                 cpu_rst,
    output logic                 busy,
    output logic                 done,
    output logic                 err_overflow,
    output logic [addr_size:0]   load_count
);

    // Release counter only needs to reach rel_cycles-1.
    localparam int rel_w = (rel_cycles > 1) ? $clog2(rel_cycles) : 1;
    localparam logic [rel_w-1:0]     rel_last    = rel_w'(rel_cycles - 1);
    localparam logic [addr_size-1:0] last_addr   = '1;
    localparam logic [addr_size:0]   depth_count = {1'b1, {addr_size{1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CLEAR,
        ST_RELEASE,
        ST_RUN
    } state_t;

    state_t               state;
    logic [addr_size-1:0] wp;
    logic [rel_w-1:0]     rel_cnt;
    logic                 accept;

    // The loader is ready for exactly as long as it is in LOAD, so an
    // accepted beat is simply a valid byte seen in that state.
    assign ld.ld_ready = (state == ST_LOAD);
    assign accept      = (state == ST_LOAD) && ld.ld_valid;

    // -------------------------------------------------------------------------
    // Sequencer FSM with registered outputs (cpu_rst, busy, done).
    // -------------------------------------------------------------------------
    // NOTE: every register here is assigned with <= so all of them see the
    // pre-edge values of each other; blocking = would make the order of
    // statements change the hardware.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= ST_IDLE;
            wp           <= '0;
            rel_cnt      <= '0;
            load_count   <= '0;
            err_overflow <= 1'b0;
            cpu_rst      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state        <= ST_LOAD;
                        wp           <= '0;
                        load_count   <= '0;
                        err_overflow <= 1'b0;
                        busy         <= 1'b1;
                    end
                end

                ST_LOAD: begin
                    // start is deliberately ignored here; a stalled source
                    // (ld_valid low) simply holds the FSM in LOAD.
                    if (accept) begin
                        wp <= wp + 1'b1;
                        if (load_count != depth_count) begin
                            load_count <= load_count + 1'b1;
                        end
                        if (wp == last_addr) begin
                            // Memory is full: no wrap. A final byte exactly at
                            // the top is legal; anything else overflowed.
                            if (!ld.ld_last) begin
                                err_overflow <= 1'b1;
                            end
                            state <= ST_RELEASE;
                        end else if (ld.ld_last) begin
                            state <= (clear_en != 0) ? ST_CLEAR : ST_RELEASE;
                        end
                    end
                end

                ST_CLEAR: begin
                    // One zero word per cycle; the write at the top address
                    // is the last one. load_count keeps the image length.
                    wp <= wp + 1'b1;
                    if (wp == last_addr) begin
                        state <= ST_RELEASE;
                    end
                end

                ST_RELEASE: begin
                    // rel_cnt enters at zero, so RELEASE lasts rel_cycles
                    // cycles; it is cleared again on the way out.
                    if (rel_cnt == rel_last) begin
                        state   <= ST_RUN;
                        rel_cnt <= '0;
                        cpu_rst <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        rel_cnt <= rel_cnt + 1'b1;
                    end
                end

                ST_RUN: begin
                    // A reload puts the processor back into reset on the same
                    // edge that enters LOAD, so it never sees a partial image.
                    if (start) begin
                        state        <= ST_LOAD;
                        cpu_rst      <= 1'b0;
                        done         <= 1'b0;
                        busy         <= 1'b1;
                        wp           <= '0;
                        load_count   <= '0;
                        err_overflow <= 1'b0;
                    end
                end

                default: begin
                    state   <= ST_IDLE;
                    cpu_rst <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Memory port mux, combinational from state.
    // -------------------------------------------------------------------------
    // NOTE: the defaults at the top give every output a value on every path,
    // so no latch is inferred whatever the case below leaves unassigned.
    always_comb begin
        mem_address = '0;
        mem_data_in = '0;
        mem_write   = 1'b0;
        case (state)
            ST_RUN: begin
                mem_address = cpu_address;
                mem_data_in = cpu_data;
                mem_write   = cpu_write;
            end
            ST_LOAD: begin
                mem_address = wp;
                mem_data_in = ld.ld_data;
                mem_write   = accept;
            end
            ST_CLEAR: begin
                mem_address = wp;
                mem_data_in = '0;
                mem_write   = 1'b1;
            end
            default: begin
                mem_address = '0;
                mem_data_in = '0;
                mem_write   = 1'b0;
            end
        endcase
    end

endmodule : spm_boot_sequencer

// File: tb/tb_spm_boot_sequencer.sv
// -----------------------------------------------------------------------------
// tb_spm_boot_sequencer
//
// Directed sequence with randomized data and valid patterns. Two sequencers
// are instantiated: dut0 with zero-fill enabled, dut1 with zero-fill
// disabled. Expected memory write streams are built from the image contents
// and the load/fill rules, then compared against what each DUT drives onto
// its memory port.
// -----------------------------------------------------------------------------
module tb_spm_boot_sequencer;

    localparam int W   = 8;
    localparam int A   = 8;
    localparam int D   = 256;
    localparam int REL = 2;

    logic         clk   = 1'b0;
    logic         rst   = 1'b0;
    logic         start = 1'b0;
    logic         valid = 1'b0;
    logic         last  = 1'b0;
    logic         sel   = 1'b0;   // 0 = stimulus goes to dut0, 1 = dut1
    logic [W-1:0] data  = '0;
    logic [A-1:0] cpu_address = '0;
    logic [W-1:0] cpu_data    = '0;
    logic         cpu_write   = 1'b0;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0]   img [0:299];
    logic [A+W-1:0] exp_log[$];
    logic [A+W-1:0] log0[$];
    logic [A+W-1:0] log1[$];

    always #5 clk = ~clk;

    spm_boot_sequencer_if #(.word_size(W)) ld0 ();
    spm_boot_sequencer_if #(.word_size(W)) ld1 ();

    assign ld0.ld_valid = valid & ~sel;
    assign ld0.ld_last  = last & ~sel;
    assign ld0.ld_data  = data;
    assign ld1.ld_valid = valid & sel;
    assign ld1.ld_last  = last & sel;
    assign ld1.ld_data  = data;

    logic [A-1:0] mem_address0, mem_address1;
    logic [W-1:0] mem_data_in0, mem_data_in1;
    logic         mem_write0, mem_write1;
    logic         cpu_rst0, cpu_rst1, busy0, busy1, done0, done1, err0, err1;
    logic [A:0]   count0, count1;

    spm_boot_sequencer #(.word_size(W), .addr_size(A), .clear_en(1), .rel_cycles(REL)) dut0 (
        .clk          (clk),
        .rst          (rst),
        .start        (start & ~sel),
        .ld           (ld0),
        .cpu_address  (cpu_address),
        .cpu_data     (cpu_data),
        .cpu_write    (cpu_write),
        .mem_address  (mem_address0),
        .mem_data_in  (mem_data_in0),
        .mem_write    (mem_write0),
        .cpu_rst      (cpu_rst0),
        .busy         (busy0),
        .done         (done0),
        .err_overflow (err0),
        .load_count   (count0)
    );

    spm_boot_sequencer #(.word_size(W), .addr_size(A), .clear_en(0), .rel_cycles(REL)) dut1 (
        .clk          (clk),
        .rst          (rst),
        .start        (start & sel),
        .ld           (ld1),
        .cpu_address  (cpu_address),
        .cpu_data     (cpu_data),
        .cpu_write    (cpu_write),
        .mem_address  (mem_address1),
        .mem_data_in  (mem_data_in1),
        .mem_write    (mem_write1),
        .cpu_rst      (cpu_rst1),
        .busy         (busy1),
        .done         (done1),
        .err_overflow (err1),
        .load_count   (count1)
    );

    // Selected-DUT views used by the shared tasks.
    wire       m_ready   = sel ? ld1.ld_ready : ld0.ld_ready;
    wire       m_cpu_rst = sel ? cpu_rst1 : cpu_rst0;
    wire       m_busy    = sel ? busy1 : busy0;
    wire       m_done    = sel ? done1 : done0;
    wire       m_err     = sel ? err1 : err0;
    wire [A:0] m_count   = sel ? count1 : count0;

    // Memory-side write monitors: what the memory would store on each edge.
    always @(posedge clk) begin
        if (mem_write0) log0.push_back({mem_address0, mem_data_in0});
        if (mem_write1) log1.push_back({mem_address1, mem_data_in1});
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Reference write stream: image words at consecutive addresses from 0
    // (never past the top of memory), then zeros to the top when the image
    // was terminated by ld_last and fill is enabled.
    task automatic build_exp(input int n, input bit has_last, input bit fill);
        exp_log.delete();
        for (int i = 0; i < n && i < D; i++) exp_log.push_back({8'(i), img[i]});
        if (has_last && fill)
            for (int a = n; a < D; a++) exp_log.push_back({8'(a), 8'h00});
    endtask

    task automatic check_log(input string tag);
        logic [A+W-1:0] got[$];
        int bad = 0;
        if (sel) got = log1; else got = log0;
        check({tag, "_wr_count"}, got.size(), exp_log.size());
        for (int i = 0; i < exp_log.size(); i++)
            if (i >= got.size() || got[i] !== exp_log[i]) bad++;
        check({tag, "_wr_seq_errors"}, bad, 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        log0.delete();
        log1.delete();
    endtask

    // Offers bytes img[0..n-1]; mode 0 = always valid, 1 = valid every other
    // cycle, 2 = random gaps. Stops when all are taken or ready drops.
    task automatic stream(input int n, input bit use_last, input int mode, output int acc);
        int cyc = 0;
        bit v;
        acc = 0;
        while (acc < n && m_ready === 1'b1 && cyc < 5000) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2) == 0;
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            valid = v;
            data  = v ? img[acc] : 8'($urandom);
            last  = v && use_last && (acc == n - 1);
            @(negedge clk);
            if (v) acc++;
            cyc++;
        end
        valid = 1'b0;
        last  = 1'b0;
    endtask

    // Counts cycles with the processor still in reset until RUN is reached.
    task automatic wait_run(input string tag, input int exp_cycles);
        int n = 0;
        int bad = 0;
        while (m_cpu_rst !== 1'b1 && n < 1000) begin
            if (m_busy !== 1'b1 || m_done !== 1'b0) bad++;
            @(negedge clk);
            n++;
        end
        check({tag, "_reset_cycles"}, n, exp_cycles);
        check({tag, "_busy_while_seq"}, bad, 0);
        check({tag, "_done_in_run"}, m_done, 1);
        check({tag, "_busy_in_run"}, m_busy, 0);
    endtask

    initial begin
        int acc;
        int n;
        int guard;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        check("rst_cpu_rst", cpu_rst0, 0);
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_err", err0, 0);
        check("rst_count", count0, 0);
        check("rst_ready", ld0.ld_ready, 0);
        check("rst_mem_write", mem_write0, 0);
        check("rst_dut1_cpu_rst", cpu_rst1, 0);
        rst = 1'b1;
        @(negedge clk);

        // ---------------- 3-byte image with zero-fill ----------------
        img[0] = 8'h51; img[1] = 8'hA2; img[2] = 8'h13;
        pulse_start();
        check("t2_busy_after_start", busy0, 1);
        stream(3, 1'b1, 0, acc);
        check("t2_accepted", acc, 3);
        wait_run("t2", (D - 3) + REL);
        build_exp(3, 1'b1, 1'b1);
        check_log("t2");
        check("t2_count", count0, 3);
        check("t2_err", err0, 0);

        // ---------------- processor owns the port in RUN ----------------
        cpu_address = 8'h1E;
        cpu_data    = 8'h7F;
        cpu_write   = 1'b1;
        #1;
        check("t4_mem_address", mem_address0, 8'h1E);
        check("t4_mem_data", mem_data_in0, 8'h7F);
        check("t4_mem_write", mem_write0, 1);
        check("t4_idle_dut_ignores_cpu", mem_write1, 0);
        pulse_start();
        #1;
        check("t4_cpu_rst_after_start", cpu_rst0, 0);
        check("t4_done_after_start", done0, 0);
        check("t4_loader_owns_write", mem_write0, 0);
        check("t4_loader_addr", mem_address0, 0);
        check("t4_ready", ld0.ld_ready, 1);
        check("t4_count_cleared", count0, 0);

        // ---------------- stalled stream, processor bus toggling ----------------
        for (int i = 0; i < 4; i++) img[i] = 8'($urandom);
        cpu_address = 8'($urandom);
        stream(4, 1'b1, 1, acc);
        cpu_write = 1'b0;
        check("t3_accepted", acc, 4);
        wait_run("t3", (D - 4) + REL);
        build_exp(4, 1'b1, 1'b1);
        check_log("t3");
        check("t3_count", count0, 4);

        // ---------------- overflow: 257 bytes, no ld_last ----------------
        for (int i = 0; i < 257; i++) img[i] = 8'($urandom);
        pulse_start();
        stream(257, 1'b0, 2, acc);
        check("t5_accepted", acc, D);
        check("t5_err", err0, 1);
        check("t5_count", count0, D);
        wait_run("t5", REL);
        build_exp(257, 1'b0, 1'b1);
        check_log("t5");
        check("t5_err_sticky", err0, 1);

        // ---------------- reset during CLEAR, then reload ----------------
        pulse_start();
        check("t6_err_cleared", err0, 0);
        for (int i = 0; i < 5; i++) img[i] = 8'($urandom);
        stream(5, 1'b1, 0, acc);
        guard = 0;
        while (mem_address0 !== 8'h40 && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        check("t6_reached_0x40", mem_address0, 8'h40);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t6_abort_mem_write", mem_write0, 0);
        check("t6_abort_cpu_rst", cpu_rst0, 0);
        check("t6_abort_busy", busy0, 0);
        check("t6_abort_ready", ld0.ld_ready, 0);
        check("t6_abort_count", count0, 0);
        @(negedge clk);
        check("t6_idle_holds", busy0, 0);
        n = $urandom_range(1, 40);
        for (int i = 0; i < n; i++) img[i] = 8'($urandom);
        pulse_start();
        stream(n, 1'b1, 2, acc);
        check("t6_accepted", acc, n);
        wait_run("t6", (D - n) + REL);
        build_exp(n, 1'b1, 1'b1);
        check_log("t6");
        check("t6_count", count0, n);

        // ---------------- no zero-fill, single byte ----------------
        sel = 1'b1;
        @(negedge clk);
        img[0] = 8'($urandom);
        pulse_start();
        stream(1, 1'b1, 0, acc);
        check("t7_accepted", acc, 1);
        check("t7_release_no_write", mem_write1, 0);
        wait_run("t7", REL);
        build_exp(1, 1'b1, 1'b0);
        check_log("t7");
        check("t7_count", m_count, 1);
        check("t7_err", m_err, 0);
        check("t7_dut0_undisturbed", done0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_spm_boot_sequencer
